// File: rtl/pcie_8b10b_pkg.sv
// Shared types and constants for the PCIe 8b/10b transmit encoder.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package pcie_8b10b_pkg;

   typedef enum logic {RD_NEG = 1'b0, RD_POS = 1'b1} rd_t;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;

   // Any K28.y plus the four K.x.7 codes with an encodable comma-free form.
   function automatic logic is_legal_k(input logic [7:0] b);
      return (b[4:0] == K28_0[4:0]) || (b == K23_7) || (b == K27_7) ||
             (b == K29_7) || (b == K30_7);
   endfunction

endpackage

// File: rtl/enc_8b10b_lut.sv
// 5b/6b + 3b/4b code tables: byte, K flag and running disparity in, 10-bit symbol and new RD out.
// Latency: combinational.
// Backpressure: none.
module enc_8b10b_lut
   import pcie_8b10b_pkg::*;
(
   input  logic [7:0] data_in,
   input  logic       k_in,
   input  rd_t        rd_in,
   output logic [9:0] sym,
   output rd_t        rd_out,
   output logic       k_err
);

   logic [4:0] x;
   logic [2:0] y;
   logic       k_ok;
   logic       k28;
   logic       rd_pos;
   logic [5:0] b6;
   logic [5:0] s6;
   logic       flip6;
   logic       rd6;
   logic [3:0] b4;
   logic [3:0] s4;
   logic       flip4;
   logic       a7;

   assign x      = data_in[4:0];
   assign y      = data_in[7:5];
   assign k_ok   = k_in && is_legal_k(data_in);
   assign k28    = k_ok && (x == 5'd28);
   assign k_err  = k_in && !k_ok;
   assign rd_pos = (rd_in == RD_POS);

   // Tables are stored in RD- form; the RD+ column is the complement for unbalanced codes and D.07.
   always_comb begin
      b6 = 6'b000000;
      case (x)
         5'd0:  b6 = 6'b100111;  5'd1:  b6 = 6'b011101;
         5'd2:  b6 = 6'b101101;  5'd3:  b6 = 6'b110001;
         5'd4:  b6 = 6'b110101;  5'd5:  b6 = 6'b101001;
         5'd6:  b6 = 6'b011001;  5'd7:  b6 = 6'b111000;
         5'd8:  b6 = 6'b111001;  5'd9:  b6 = 6'b100101;
         5'd10: b6 = 6'b010101;  5'd11: b6 = 6'b110100;
         5'd12: b6 = 6'b001101;  5'd13: b6 = 6'b101100;
         5'd14: b6 = 6'b011100;  5'd15: b6 = 6'b010111;
         5'd16: b6 = 6'b011011;  5'd17: b6 = 6'b100011;
         5'd18: b6 = 6'b010011;  5'd19: b6 = 6'b110010;
         5'd20: b6 = 6'b001011;  5'd21: b6 = 6'b101010;
         5'd22: b6 = 6'b011010;  5'd23: b6 = 6'b111010;
         5'd24: b6 = 6'b110011;  5'd25: b6 = 6'b100110;
         5'd26: b6 = 6'b010110;  5'd27: b6 = 6'b110110;
         5'd28: b6 = 6'b001110;  5'd29: b6 = 6'b101110;
         5'd30: b6 = 6'b011110;  default: b6 = 6'b101011;
      endcase
      if (k28) b6 = 6'b001111;
      flip6 = ($countones(b6) != 3) || (x == 5'd7);
      s6    = (rd_pos && flip6) ? ~b6 : b6;
      rd6   = rd_pos ^ ($countones(s6) != 3);

      // A7 avoids a run of five identical bits across the sub-block boundary; legal K.x.7 always uses it.
      a7 = (y == 3'd7) && (k_ok ||
           (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
           ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
      b4 = 4'b0000;
      case (y)
         3'd0: b4 = 4'b1011;  3'd1: b4 = 4'b1001;
         3'd2: b4 = 4'b0101;  3'd3: b4 = 4'b1100;
         3'd4: b4 = 4'b1101;  3'd5: b4 = 4'b1010;
         3'd6: b4 = 4'b0110;  default: b4 = a7 ? 4'b0111 : 4'b1110;
      endcase
      flip4 = ($countones(b4) != 2) || (y == 3'd3);
      // K28 balanced 4b codes are the inverted D forms and still swap with RD.
      if (k28 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6)) begin
         b4    = ~b4;
         flip4 = 1'b1;
      end
      s4     = (rd6 && flip4) ? ~b4 : b4;
      rd_out = rd_t'(rd6 ^ ($countones(s4) != 2));
      sym    = {s6, s4};
   end

endmodule

// File: rtl/enc_8b10b_tx.sv
// PCIe TX 8b/10b encoder: one byte per cycle to a 10-bit symbol with running-disparity tracking.
// Latency: 1 clk from an accepted byte to data_out/valid_out/crd_bit/err.
// Backpressure: none; every valid_in byte is accepted.
module enc_8b10b_tx
   import pcie_8b10b_pkg::*;
#(
   parameter int   iWIDTH  = 8,
   parameter int   oWIDTH  = 10,
   parameter logic RD_INIT = 1'b0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [iWIDTH-1:0] data_in,
   input  logic              k_in,
   input  logic              valid_in,
   output logic [oWIDTH-1:0] data_out,
   output logic              valid_out,
   output logic              crd_bit,
   output logic              err
);

   rd_t         rd_q;
   rd_t         rd_nxt;
   logic [9:0]  sym;
   logic        k_err;

   enc_8b10b_lut u_lut (
      .data_in (data_in),
      .k_in    (k_in),
      .rd_in   (rd_q),
      .sym     (sym),
      .rd_out  (rd_nxt),
      .k_err   (k_err)
   );

   // The RD register doubles as crd_bit, so the reported disparity can never drift from the one used.
   assign crd_bit = (rd_q == RD_POS);

   // Register the symbol; idle cycles hold data_out and RD and drop valid_out/err.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q      <= rd_t'(RD_INIT);
         data_out  <= '0;
         valid_out <= 1'b0;
         err       <= 1'b0;
      end else begin
         valid_out <= valid_in;
         err       <= valid_in && k_err;
         if (valid_in) begin
            data_out <= sym;
            rd_q     <= rd_nxt;
         end
      end
   end

endmodule

// File: tb/tb_enc_8b10b_tx.sv
// Scoreboard bench for enc_8b10b_tx with an explicit two-column code-table model and a receive-side RD checker.
// Latency: expects each accepted byte one clock later.
// Backpressure: none exercised; gaps are driven with valid_in=0.
module tb_enc_8b10b_tx;

   typedef struct {
      logic [9:0] sym;
      logic       crd;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       k_in = 1'b0;
   logic       valid_in = 1'b0;
   logic [9:0] data_out;
   logic       valid_out;
   logic       crd_bit;
   logic       err;

   int checks = 0;
   int failures = 0;
   exp_t q[$];
   logic m_rd = 1'b0;

   // 6b codes indexed by EDCBA, one table per current RD.
   logic [5:0] t6n [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
   logic [5:0] t6p [32] = '{
      6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
      6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
      6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
   // 4b codes indexed by HGF, by RD after the 6b sub-block (data P7 at index 7, K28 separately).
   logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
   logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
   logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
   logic [7:0] klist [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE};

   enc_8b10b_tx #(.iWIDTH(8), .oWIDTH(10), .RD_INIT(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .k_in      (k_in),
      .valid_in  (valid_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .crd_bit   (crd_bit),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] d, input logic k, input logic rd);
      exp_t       e;
      logic       legal = 1'b0;
      logic [4:0] x = d[4:0];
      logic [2:0] y = d[7:5];
      logic [5:0] s6;
      logic [3:0] s4;
      logic       r6;
      logic       alt;
      if (k) for (int i = 0; i < 12; i++) if (klist[i] == d) legal = 1'b1;
      if (legal && x == 5'd28) s6 = rd ? 6'b110000 : 6'b001111;
      else                     s6 = rd ? t6p[x] : t6n[x];
      r6 = rd ^ ($countones(s6) != 3);
      alt = (y == 3'd7) && (legal || (!r6 && (x == 17 || x == 18 || x == 20)) ||
                                     (r6 && (x == 11 || x == 13 || x == 14)));
      if (legal && x == 5'd28) s4 = r6 ? k4p[y] : k4n[y];
      else if (alt)            s4 = r6 ? 4'b1000 : 4'b0111;
      else                     s4 = r6 ? t4p[y] : t4n[y];
      e.sym = {s6, s4};
      e.crd = r6 ^ ($countones(s4) != 2);
      e.err = k && !legal;
      return e;
   endfunction

   // Receive-side disparity rules applied to each sub-block of the transmitted symbol.
   task automatic rx_check(input logic [9:0] s, input logic rd, output logic ok, output logic nrd);
      int   o6 = $countones(s[9:4]);
      int   o4 = $countones(s[3:0]);
      logic r  = rd;
      ok = 1'b1;
      if (o6 == 4)      begin if (r) ok = 1'b0; r = 1'b1; end
      else if (o6 == 2) begin if (!r) ok = 1'b0; r = 1'b0; end
      else if (o6 != 3) ok = 1'b0;
      else if ((s[9:4] == 6'b111000 && r) || (s[9:4] == 6'b000111 && !r)) ok = 1'b0;
      if (o4 == 3)      begin if (r) ok = 1'b0; r = 1'b1; end
      else if (o4 == 1) begin if (!r) ok = 1'b0; r = 1'b0; end
      else if (o4 != 2) ok = 1'b0;
      else if ((s[3:0] == 4'b1100 && r) || (s[3:0] == 4'b0011 && !r)) ok = 1'b0;
      nrd = r;
   endtask

   task automatic drive(input logic [7:0] d, input logic k, input logic v);
      @(posedge clk); #1;
      rst = 1'b0; data_in = d; k_in = k; valid_in = v;
   endtask

   task automatic send(input logic [7:0] d, input logic k);
      exp_t e;
      drive(d, k, 1'b1);
      e = model(d, k, m_rd);
      m_rd = e.crd;
      q.push_back(e);
   endtask

   task automatic send_lit(input logic [7:0] d, input logic k, input logic [9:0] s,
                           input logic c, input logic er);
      exp_t e;
      drive(d, k, 1'b1);
      e = model(d, k, m_rd);
      m_rd = e.crd;
      e.sym = s; e.crd = c; e.err = er;
      q.push_back(e);
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1;
      rst = 1'b1; valid_in = 1'b1; k_in = 1'b0; data_in = 8'($urandom);
      m_rd = 1'b0;
   endtask

   // Monitor: pops expectations on valid_out, checks hold behaviour on idle and reset cycles.
   initial begin : monitor
      logic       rst_prev = 1'b0;
      logic [9:0] hold_dat = 10'd0;
      logic       hold_crd = 1'b0;
      logic       chk_rd = 1'b0;
      logic       ok, nrd;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            checks++;
            if (valid_out !== 1'b0 || data_out !== 10'd0 || crd_bit !== 1'b0 || err !== 1'b0) begin
               failures++;
               $display("FAIL reset: vo=%b do=%b crd=%b err=%b, need 0 0000000000 0 0",
                        valid_out, data_out, crd_bit, err);
            end
            hold_dat = 10'd0; hold_crd = 1'b0; chk_rd = 1'b0;
         end else if (valid_out === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_symbol: do=%b with no byte outstanding", data_out);
            end else begin
               e = q.pop_front();
               if (data_out !== e.sym || crd_bit !== e.crd || err !== e.err) begin
                  failures++;
                  $display("FAIL symbol: do=%b crd=%b err=%b, need %b %b %b",
                           data_out, crd_bit, err, e.sym, e.crd, e.err);
               end
               hold_dat = e.sym; hold_crd = e.crd;
            end
            rx_check(data_out, chk_rd, ok, nrd);
            checks++;
            if (!ok || nrd !== crd_bit) begin
               failures++;
               $display("FAIL rx_disparity: do=%b rd_in=%b ok=%b rx_crd=%b enc_crd=%b",
                        data_out, chk_rd, ok, nrd, crd_bit);
            end
            chk_rd = nrd;
         end else begin
            checks++;
            if (valid_out !== 1'b0 || err !== 1'b0 || data_out !== hold_dat || crd_bit !== hold_crd) begin
               failures++;
               $display("FAIL idle_hold: vo=%b err=%b do=%b crd=%b, need 0 0 %b %b",
                        valid_out, err, data_out, crd_bit, hold_dat, hold_crd);
            end
         end
         rst_prev = rst;
      end
   end

   // Stimulus: directed symbols, then randomized traffic with a mid-stream reset.
   initial begin : stim
      int r;
      int waited;
      repeat (3) @(posedge clk);
      drive(8'h00, 1'b0, 1'b0);
      send_lit(8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
      send_lit(K28_5_v(), 1'b1, 10'b0011111010, 1'b1, 1'b0);
      send_lit(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);
      send_lit(8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0);
      send_lit(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
      send_lit(8'hB5, 1'b0, 10'b1010101010, 1'b1, 1'b0);
      send_lit(8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);
      send_lit(8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0);
      send_lit(8'hF1, 1'b0, 10'b1000110001, 1'b0, 1'b0);
      send_lit(8'h00, 1'b1, 10'b1001110100, 1'b0, 1'b1);
      drive(8'h5A, 1'b1, 1'b0);
      drive(8'hA5, 1'b0, 1'b0);
      send_lit(8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) begin
            send(8'($urandom), 1'b0);
            pulse_rst();
            send_lit(8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
         end
         r = $urandom_range(0, 99);
         if (r < 70)      send(8'($urandom), 1'b0);
         else if (r < 85) send(klist[$urandom_range(0, 11)], 1'b1);
         else if (r < 90) send(8'($urandom), 1'b1);
         else             drive(8'($urandom), 1'($urandom), 1'b0);
      end
      drive(8'h00, 1'b0, 1'b0);
      waited = 0;
      while (q.size() != 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d symbols outstanding, need 0", q.size());
      end
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic logic [7:0] K28_5_v();
      return 8'hBC;
   endfunction

endmodule
